// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - decode, RAW scoreboard with WB forwarding, registered issue toward execute
module decode_issue_stage #(
  parameter int REG_AW     = 4,
  parameter int DATA_W     = 16,
  parameter int PEND_W     = 2,
  parameter int IMM_SIGNED = 1,
  localparam int INSTR_W   = 4 + 3 * REG_AW
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [INSTR_W-1:0] IRIN,
  input  logic [DATA_W-1:0]  PCIN,
  input  logic               INVALID,
  output logic               INREADY,
  output logic [REG_AW-1:0]  RADDR1,
  output logic [REG_AW-1:0]  RADDR2,
  input  logic [DATA_W-1:0]  RDATA1,
  input  logic [DATA_W-1:0]  RDATA2,
  input  logic               WB_VALID,
  input  logic [REG_AW-1:0]  WB_REG,
  input  logic [DATA_W-1:0]  WB_DATA,
  input  logic               FLUSH,
  output logic               OUTVALID,
  input  logic               OUTREADY,
  output logic [INSTR_W-1:0] IROUT,
  output logic [DATA_W-1:0]  PCOUT,
  output logic [DATA_W-1:0]  DATAOUT1,
  output logic [DATA_W-1:0]  DATAOUT2,
  output logic [DATA_W-1:0]  DATAOUT3,
  output logic               WILLWRITE,
  output logic [REG_AW-1:0]  STARTREG,
  output logic               ILLEGAL
);
  localparam int NREG = 1 << REG_AW;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_JUMP = 4'd10;

  logic [3:0]          op;
  logic [REG_AW-1:0]   r1, r2, r3, src_a, src_b;
  logic [2*REG_AW-1:0] im;
  logic                is_alu, use_a, use_b, writes, illegal_n;
  logic [DATA_W-1:0]   ext_im, ext_off, r1_z, tgt_z, val_a, val_b;
  logic [DATA_W-1:0]   d1_n, d2_n, d3_n;
  logic                wb_hit_a, wb_hit_b, haz_a, haz_b, full, stall, accept, hs;

  logic               valid_q, valid_d, ww_q, ww_d, ill_q, ill_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  pc_q, pc_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [REG_AW-1:0]  sr_q, sr_d;
  logic [PEND_W-1:0]  cnt_q [NREG];
  logic [PEND_W-1:0]  cnt_d [NREG];

  always_comb begin
    op        = IRIN[INSTR_W-1 -: 4];
    r1        = IRIN[3*REG_AW-1 -: REG_AW];
    r2        = IRIN[2*REG_AW-1 -: REG_AW];
    r3        = IRIN[REG_AW-1:0];
    im        = IRIN[2*REG_AW-1:0];
    is_alu    = (op >= OP_ADD) && (op <= OP_SLT);
    illegal_n = op > OP_JUMP;
    use_a     = 1'b0;
    use_b     = 1'b0;
    src_a     = '0;
    src_b     = '0;
    if (is_alu) begin
      use_a = 1'b1;
      src_a = r2;
      use_b = 1'b1;
      src_b = r3;
    end else if (op == OP_SW) begin
      use_a = 1'b1;
      src_a = r1;
    end else if (op == OP_BEQ) begin
      use_a = 1'b1;
      src_a = r1;
      use_b = 1'b1;
      src_b = r2;
    end
    writes  = (is_alu || op == OP_ADDI || op == OP_LW) && (r1 != '0);
    ext_im  = {{(DATA_W-2*REG_AW){(IMM_SIGNED != 0) && im[2*REG_AW-1]}}, im};
    ext_off = {{(DATA_W-REG_AW){(IMM_SIGNED != 0) && r3[REG_AW-1]}}, r3};
    r1_z    = {{(DATA_W-REG_AW){1'b0}}, r1};
    tgt_z   = {{(DATA_W-2*REG_AW){1'b0}}, im};
  end

  assign RADDR1   = src_a;
  assign RADDR2   = src_b;
  assign wb_hit_a = WB_VALID && (WB_REG == src_a);
  assign wb_hit_b = WB_VALID && (WB_REG == src_b);
  assign val_a    = wb_hit_a ? WB_DATA : RDATA1;
  assign val_b    = wb_hit_b ? WB_DATA : RDATA2;

  // A retiring WB to the source cancels one pending write; the held output still counts.
  assign haz_a = use_a && (src_a != '0) &&
                 ((cnt_q[src_a] > PEND_W'(wb_hit_a)) || (valid_q && ww_q && sr_q == src_a));
  assign haz_b = use_b && (src_b != '0) &&
                 ((cnt_q[src_b] > PEND_W'(wb_hit_b)) || (valid_q && ww_q && sr_q == src_b));
  assign full    = writes && (cnt_q[r1] == {PEND_W{1'b1}});
  assign stall   = INVALID && (haz_a || haz_b || full);
  assign INREADY = !stall && !FLUSH && (!valid_q || OUTREADY);
  assign accept  = INVALID && INREADY;
  assign hs      = valid_q && OUTREADY;

  always_comb begin
    d1_n = '0;
    d2_n = '0;
    d3_n = '0;
    if (is_alu) begin
      d1_n = r1_z;
      d2_n = val_a;
      d3_n = val_b;
    end else begin
      case (op)
        OP_ADDI, OP_LW: begin
          d1_n = r1_z;
          d2_n = ext_im;
        end
        OP_SW: begin
          d1_n = val_a;
          d2_n = ext_im;
        end
        OP_BEQ: begin
          d1_n = val_a;
          d2_n = val_b;
          d3_n = ext_off;
        end
        OP_JUMP: d1_n = tgt_z;
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    ww_d    = ww_q;
    sr_d    = sr_q;
    ill_d   = ill_q;
    if (accept) begin
      valid_d = 1'b1;
      ir_d    = IRIN;
      pc_d    = PCIN;
      d1_d    = d1_n;
      d2_d    = d2_n;
      d3_d    = d3_n;
      ww_d    = writes;
      sr_d    = writes ? r1 : '0;
      ill_d   = illegal_n;
    end else if (FLUSH || hs) begin
      valid_d = 1'b0;
      ir_d    = '0;
      pc_d    = '0;
      d1_d    = '0;
      d2_d    = '0;
      d3_d    = '0;
      ww_d    = 1'b0;
      sr_d    = '0;
      ill_d   = 1'b0;
    end
  end

  // Issue handshake and writeback on the same register cancel out.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if ((hs && ww_q && sr_q == REG_AW'(r)) && !(WB_VALID && WB_REG == REG_AW'(r))) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (!(hs && ww_q && sr_q == REG_AW'(r)) && WB_VALID && WB_REG == REG_AW'(r)
                   && cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      ww_q    <= 1'b0;
      sr_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      ww_q    <= ww_d;
      sr_q    <= sr_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign OUTVALID  = valid_q;
  assign IROUT     = ir_q;
  assign PCOUT     = pc_q;
  assign DATAOUT1  = d1_q;
  assign DATAOUT2  = d2_q;
  assign DATAOUT3  = d3_q;
  assign WILLWRITE = ww_q;
  assign STARTREG  = sr_q;
  assign ILLEGAL   = ill_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - directed-vector bench for decode_issue_stage (signed and unsigned immediates)
module tb_decode_issue_stage;
  logic        CLK = 1'b0;
  logic        RST, INVALID, WB_VALID, FLUSH, OUTREADY;
  logic [15:0] IRIN, PCIN, RDATA1, RDATA2, WB_DATA;
  logic [3:0]  WB_REG;
  logic        INREADY, OUTVALID, WILLWRITE, ILLEGAL;
  logic [3:0]  RADDR1, RADDR2, STARTREG;
  logic [15:0] IROUT, PCOUT, DATAOUT1, DATAOUT2, DATAOUT3;
  logic        z_inready, z_outvalid, z_willwrite, z_illegal;
  logic [3:0]  z_raddr1, z_raddr2, z_startreg;
  logic [15:0] z_irout, z_pcout, z_dataout1, z_dataout2, z_dataout3;
  int vecs = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  decode_issue_stage #(.REG_AW(4), .DATA_W(16), .PEND_W(2), .IMM_SIGNED(1)) u_dut (
    .CLK(CLK), .RST(RST), .IRIN(IRIN), .PCIN(PCIN), .INVALID(INVALID), .INREADY(INREADY),
    .RADDR1(RADDR1), .RADDR2(RADDR2), .RDATA1(RDATA1), .RDATA2(RDATA2),
    .WB_VALID(WB_VALID), .WB_REG(WB_REG), .WB_DATA(WB_DATA), .FLUSH(FLUSH),
    .OUTVALID(OUTVALID), .OUTREADY(OUTREADY), .IROUT(IROUT), .PCOUT(PCOUT),
    .DATAOUT1(DATAOUT1), .DATAOUT2(DATAOUT2), .DATAOUT3(DATAOUT3),
    .WILLWRITE(WILLWRITE), .STARTREG(STARTREG), .ILLEGAL(ILLEGAL)
  );

  decode_issue_stage #(.REG_AW(4), .DATA_W(16), .PEND_W(2), .IMM_SIGNED(0)) u_dut_z (
    .CLK(CLK), .RST(RST), .IRIN(IRIN), .PCIN(PCIN), .INVALID(INVALID), .INREADY(z_inready),
    .RADDR1(z_raddr1), .RADDR2(z_raddr2), .RDATA1(RDATA1), .RDATA2(RDATA2),
    .WB_VALID(WB_VALID), .WB_REG(WB_REG), .WB_DATA(WB_DATA), .FLUSH(FLUSH),
    .OUTVALID(z_outvalid), .OUTREADY(OUTREADY), .IROUT(z_irout), .PCOUT(z_pcout),
    .DATAOUT1(z_dataout1), .DATAOUT2(z_dataout2), .DATAOUT3(z_dataout3),
    .WILLWRITE(z_willwrite), .STARTREG(z_startreg), .ILLEGAL(z_illegal)
  );

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; INVALID = 1'b1; IRIN = 16'h1312; PCIN = 16'h0010;
    repeat (3) next_cycle();
    RST = 1'b0; INVALID = 1'b0;
    mid();
    vecs++; if (OUTVALID !== 1'b0) begin errs++; $display("FAIL rst_outvalid got %h want 0", OUTVALID); end
    vecs++; if (IROUT !== 16'h0) begin errs++; $display("FAIL rst_irout got %h want 0000", IROUT); end
    vecs++; if (PCOUT !== 16'h0) begin errs++; $display("FAIL rst_pcout got %h want 0000", PCOUT); end
    vecs++; if ({DATAOUT1, DATAOUT2, DATAOUT3} !== 48'h0) begin errs++; $display("FAIL rst_data got %h %h %h want 0", DATAOUT1, DATAOUT2, DATAOUT3); end
    vecs++; if ({WILLWRITE, ILLEGAL, STARTREG} !== 6'h0) begin errs++; $display("FAIL rst_flags got ww=%h ill=%h sr=%h want 0", WILLWRITE, ILLEGAL, STARTREG); end
    next_cycle();
  endtask

  task automatic test_add();
    IRIN = 16'h1312; PCIN = 16'h0040; INVALID = 1'b1; RDATA1 = 16'd5; RDATA2 = 16'd7;
    mid();
    vecs++; if ({RADDR1, RADDR2} !== 8'h12) begin errs++; $display("FAIL add_raddr got %h %h want 1 2", RADDR1, RADDR2); end
    vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL add_inready got %h want 1", INREADY); end
    next_cycle();
    INVALID = 1'b0; RDATA1 = 16'h0; RDATA2 = 16'h0;
    mid();
    vecs++; if (OUTVALID !== 1'b1) begin errs++; $display("FAIL add_outvalid got %h want 1", OUTVALID); end
    vecs++; if ({DATAOUT1, DATAOUT2, DATAOUT3} !== {16'd3, 16'd5, 16'd7}) begin errs++; $display("FAIL add_data got %h %h %h want 0003 0005 0007", DATAOUT1, DATAOUT2, DATAOUT3); end
    vecs++; if ({WILLWRITE, STARTREG} !== 5'h13) begin errs++; $display("FAIL add_dest got ww=%h sr=%h want 1 3", WILLWRITE, STARTREG); end
    vecs++; if (PCOUT !== 16'h0040) begin errs++; $display("FAIL add_pcout got %h want 0040", PCOUT); end
    next_cycle();
    mid();
    vecs++; if ({OUTVALID, DATAOUT2} !== 17'h0) begin errs++; $display("FAIL add_drain got v=%h d2=%h want 0 0", OUTVALID, DATAOUT2); end
    next_cycle();
    WB_VALID = 1'b1; WB_REG = 4'd3; WB_DATA = 16'h0;
    next_cycle();
    WB_VALID = 1'b0;
  endtask

  task automatic test_raw_forward();
    IRIN = 16'h1312; INVALID = 1'b1; RDATA1 = 16'd5; RDATA2 = 16'd7;
    mid();
    vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL raw_first got %h want 1", INREADY); end
    next_cycle();
    IRIN = 16'h2431; RDATA1 = 16'h0099; RDATA2 = 16'h0005;
    mid();
    vecs++; if (INREADY !== 1'b0) begin errs++; $display("FAIL raw_outreg got %h want 0", INREADY); end
    vecs++; if ({RADDR1, RADDR2} !== 8'h31) begin errs++; $display("FAIL raw_raddr got %h %h want 3 1", RADDR1, RADDR2); end
    next_cycle();
    mid();
    vecs++; if ({INREADY, OUTVALID} !== 2'b00) begin errs++; $display("FAIL raw_pending got rdy=%h v=%h want 0 0", INREADY, OUTVALID); end
    next_cycle();
    WB_VALID = 1'b1; WB_REG = 4'd3; WB_DATA = 16'h000C;
    mid();
    vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL raw_wb_release got %h want 1", INREADY); end
    next_cycle();
    WB_VALID = 1'b0; INVALID = 1'b0;
    mid();
    vecs++; if ({OUTVALID, IROUT} !== {1'b1, 16'h2431}) begin errs++; $display("FAIL raw_issue got v=%h ir=%h want 1 2431", OUTVALID, IROUT); end
    vecs++; if ({DATAOUT1, DATAOUT2, DATAOUT3} !== {16'd4, 16'h000C, 16'd5}) begin errs++; $display("FAIL raw_fwd_data got %h %h %h want 0004 000c 0005", DATAOUT1, DATAOUT2, DATAOUT3); end
    vecs++; if (STARTREG !== 4'd4) begin errs++; $display("FAIL raw_startreg got %h want 4", STARTREG); end
    next_cycle();
    WB_VALID = 1'b1; WB_REG = 4'd4;
    next_cycle();
    WB_VALID = 1'b0;
  endtask

  task automatic test_imm();
    IRIN = 16'h61F0; INVALID = 1'b1;
    mid();
    vecs++; if ({RADDR1, RADDR2, INREADY} !== 9'h001) begin errs++; $display("FAIL imm_accept got ra=%h %h rdy=%h want 0 0 1", RADDR1, RADDR2, INREADY); end
    next_cycle();
    INVALID = 1'b0;
    mid();
    vecs++; if (DATAOUT2 !== 16'hFFF0) begin errs++; $display("FAIL imm_signed got %h want fff0", DATAOUT2); end
    vecs++; if (z_dataout2 !== 16'h00F0) begin errs++; $display("FAIL imm_unsigned got %h want 00f0", z_dataout2); end
    vecs++; if ({DATAOUT1, DATAOUT3} !== {16'd1, 16'd0}) begin errs++; $display("FAIL imm_d1d3 got %h %h want 0001 0000", DATAOUT1, DATAOUT3); end
    vecs++; if ({WILLWRITE, STARTREG} !== 5'h11) begin errs++; $display("FAIL imm_dest got ww=%h sr=%h want 1 1", WILLWRITE, STARTREG); end
    next_cycle();
    WB_VALID = 1'b1; WB_REG = 4'd1;
    next_cycle();
    WB_VALID = 1'b0;
  endtask

  task automatic test_backpressure();
    IRIN = 16'h912E; INVALID = 1'b1; RDATA1 = 16'h1111; RDATA2 = 16'h2222;
    mid();
    vecs++; if ({INREADY, RADDR1, RADDR2} !== 9'h112) begin errs++; $display("FAIL beq_accept got rdy=%h ra=%h %h want 1 1 2", INREADY, RADDR1, RADDR2); end
    next_cycle();
    OUTREADY = 1'b0; IRIN = 16'hA0AB; RDATA1 = 16'hDEAD; RDATA2 = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      mid();
      vecs++; if ({OUTVALID, IROUT, INREADY} !== {1'b1, 16'h912E, 1'b0}) begin errs++; $display("FAIL bp_hold[%0d] got v=%h ir=%h rdy=%h want 1 912e 0", i, OUTVALID, IROUT, INREADY); end
      vecs++; if ({DATAOUT1, DATAOUT2, DATAOUT3} !== {16'h1111, 16'h2222, 16'hFFFE}) begin errs++; $display("FAIL bp_data[%0d] got %h %h %h want 1111 2222 fffe", i, DATAOUT1, DATAOUT2, DATAOUT3); end
      next_cycle();
    end
    mid();
    vecs++; if (z_dataout3 !== 16'h000E) begin errs++; $display("FAIL beq_off_unsigned got %h want 000e", z_dataout3); end
    vecs++; if ({RADDR1, RADDR2} !== 8'h00) begin errs++; $display("FAIL jump_raddr got %h %h want 0 0", RADDR1, RADDR2); end
    next_cycle();
    OUTREADY = 1'b1;
    mid();
    vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL bp_release got %h want 1", INREADY); end
    next_cycle();
    INVALID = 1'b0;
    mid();
    vecs++; if ({IROUT, DATAOUT1, DATAOUT2, DATAOUT3} !== {16'hA0AB, 16'h00AB, 16'h0, 16'h0}) begin errs++; $display("FAIL jump_out got ir=%h d=%h %h %h want a0ab 00ab 0 0", IROUT, DATAOUT1, DATAOUT2, DATAOUT3); end
    vecs++; if (WILLWRITE !== 1'b0) begin errs++; $display("FAIL jump_ww got %h want 0", WILLWRITE); end
    next_cycle();
  endtask

  task automatic test_full();
    IRIN = 16'h7500; INVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL lw_issue[%0d] got %h want 1", i, INREADY); end
      next_cycle();
    end
    INVALID = 1'b0;
    next_cycle();
    INVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      vecs++; if (INREADY !== 1'b0) begin errs++; $display("FAIL lw_full[%0d] got %h want 0", i, INREADY); end
      next_cycle();
    end
    WB_VALID = 1'b1; WB_REG = 4'd5; WB_DATA = 16'h0;
    next_cycle();
    WB_VALID = 1'b0;
    mid();
    vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL lw_unfull got %h want 1", INREADY); end
    next_cycle();
    INVALID = 1'b0;
    mid();
    vecs++; if ({OUTVALID, WILLWRITE, STARTREG, DATAOUT1} !== {1'b1, 1'b1, 4'd5, 16'd5}) begin errs++; $display("FAIL lw4_out got v=%h ww=%h sr=%h d1=%h want 1 1 5 0005", OUTVALID, WILLWRITE, STARTREG, DATAOUT1); end
    next_cycle();
    WB_VALID = 1'b1; WB_REG = 4'd5;
    repeat (2) next_cycle();
    WB_VALID = 1'b0; IRIN = 16'h1650; INVALID = 1'b1; RDATA1 = 16'h3333; RDATA2 = 16'h0;
    mid();
    vecs++; if (INREADY !== 1'b0) begin errs++; $display("FAIL cnt_one_pending got %h want 0", INREADY); end
    next_cycle();
    WB_VALID = 1'b1; WB_REG = 4'd5; WB_DATA = 16'h0077;
    mid();
    vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL cnt_wb_cancel got %h want 1", INREADY); end
    next_cycle();
    WB_VALID = 1'b0; INVALID = 1'b0;
    mid();
    vecs++; if ({DATAOUT1, DATAOUT2, DATAOUT3} !== {16'd6, 16'h0077, 16'h0}) begin errs++; $display("FAIL cnt_fwd_data got %h %h %h want 0006 0077 0000", DATAOUT1, DATAOUT2, DATAOUT3); end
    next_cycle();
  endtask

  task automatic test_flush_illegal();
    IRIN = 16'h6205; INVALID = 1'b1;
    mid();
    next_cycle();
    OUTREADY = 1'b0; IRIN = 16'h6707; FLUSH = 1'b1;
    mid();
    vecs++; if ({INREADY, OUTVALID} !== 2'b01) begin errs++; $display("FAIL flush_cycle got rdy=%h v=%h want 0 1", INREADY, OUTVALID); end
    next_cycle();
    FLUSH = 1'b0; INVALID = 1'b0; OUTREADY = 1'b1;
    mid();
    vecs++; if ({OUTVALID, IROUT, DATAOUT1, DATAOUT2} !== 49'h0) begin errs++; $display("FAIL flush_out got v=%h ir=%h d=%h %h want 0", OUTVALID, IROUT, DATAOUT1, DATAOUT2); end
    next_cycle();
    IRIN = 16'h1120; INVALID = 1'b1;
    mid();
    vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL flush_no_count got %h want 1", INREADY); end
    next_cycle();
    IRIN = 16'hD123;
    mid();
    vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL ill_accept got %h want 1", INREADY); end
    next_cycle();
    INVALID = 1'b0;
    mid();
    vecs++; if ({OUTVALID, ILLEGAL, WILLWRITE, IROUT} !== {1'b1, 1'b1, 1'b0, 16'hD123}) begin errs++; $display("FAIL ill_flags got v=%h ill=%h ww=%h ir=%h want 1 1 0 d123", OUTVALID, ILLEGAL, WILLWRITE, IROUT); end
    vecs++; if ({DATAOUT1, DATAOUT2, DATAOUT3} !== 48'h0) begin errs++; $display("FAIL ill_data got %h %h %h want 0", DATAOUT1, DATAOUT2, DATAOUT3); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    IRIN = 16'h8100; INVALID = 1'b1;
    mid();
    vecs++; if (INREADY !== 1'b0) begin errs++; $display("FAIL sw_pending got %h want 0", INREADY); end
    next_cycle();
    IRIN = 16'h6303; OUTREADY = 1'b0;
    next_cycle();
    RST = 1'b1; INVALID = 1'b0;
    mid();
    vecs++; if (OUTVALID !== 1'b1) begin errs++; $display("FAIL pre_rst_valid got %h want 1", OUTVALID); end
    next_cycle();
    RST = 1'b0;
    mid();
    vecs++; if ({OUTVALID, IROUT, STARTREG} !== 21'h0) begin errs++; $display("FAIL mid_rst_out got v=%h ir=%h sr=%h want 0", OUTVALID, IROUT, STARTREG); end
    next_cycle();
    IRIN = 16'h8100; INVALID = 1'b1; OUTREADY = 1'b1;
    mid();
    vecs++; if (INREADY !== 1'b1) begin errs++; $display("FAIL rst_clears_cnt got %h want 1", INREADY); end
    next_cycle();
    INVALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1; INVALID = 1'b0; WB_VALID = 1'b0; FLUSH = 1'b0; OUTREADY = 1'b1;
    IRIN = 16'h0; PCIN = 16'h0; RDATA1 = 16'h0; RDATA2 = 16'h0; WB_DATA = 16'h0; WB_REG = 4'h0;
    test_reset();
    test_add();
    test_raw_forward();
    test_imm();
    test_backpressure();
    test_full();
    test_flush_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Parametrised successor to the fixed 16-bit decode/operand-fetch stage.
- Decodes one instruction per cycle and drives register-file read addresses.
- Applies RAW hazard detection with a per-register pending-write scoreboard and WB forwarding.
- Registers decoded operands toward execute through a valid/ready handshake with stall and flush.
- Sits between fetch and execute; single posedge timing, no negedge half-stage.

Parameters:
- REG_AW, 4: register address width; INSTR_W = 4 + 3*REG_AW (op | reg1 | reg2 | reg3).
- DATA_W, 16: operand width; must be >= INSTR_W.
- PEND_W, 2: scoreboard counter width; at most 2^PEND_W-1 in-flight writes per register.
- IMM_SIGNED, 1: 1 = sign-extend im/offset to DATA_W; 0 = zero-extend.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- IRIN  in  INSTR_W  instruction from fetch.
- PCIN  in  DATA_W  PC of IRIN.
- INVALID  in  1  IRIN/PCIN valid.
- INREADY  out  1  stage accepts IRIN this cycle.
- RADDR1, RADDR2  out  REG_AW  register-file read addresses (combinational from IRIN).
- RDATA1, RDATA2  in  DATA_W  register-file read data, same cycle.
- WB_VALID  in  1  writeback retiring this cycle.
- WB_REG  in  REG_AW  writeback destination.
- WB_DATA  in  DATA_W  writeback value (forwarding source).
- FLUSH  in  1  squash input and held output.
- OUTVALID  out  1  output register valid.
- OUTREADY  in  1  execute accepts output.
- IROUT  out  INSTR_W  registered instruction.
- PCOUT  out  DATA_W  registered PC.
- DATAOUT1, DATAOUT2, DATAOUT3  out  DATA_W  decoded operands.
- WILLWRITE  out  1  output instruction writes a register.
- STARTREG  out  REG_AW  destination register of output instruction.
- ILLEGAL  out  1  output opcode undefined.

Behaviour:
- Fields: op = IR[INSTR_W-1 -: 4]; reg1, reg2, reg3 follow in descending order.
- Field slices: im/target = IR[2*REG_AW-1:0]; offset = IR[REG_AW-1:0].
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 ADDI, 7 LW, 8 SW, 9 BEQ, 10 JUMP; 11-15 illegal.
- Illegal opcodes are handled as NOP with ILLEGAL=1 and IROUT passed through.
- Sources and reads:
  - R-type (1-5): srcA = reg2, srcB = reg3; RADDR1 = reg2, RADDR2 = reg3.
  - SW: srcA = reg1.
  - BEQ: srcA = reg1, srcB = reg2.
  - All other ops: no sources; unused RADDR outputs are 0.
- Destination: R-type, ADDI and LW write reg1; register 0 never counts as a write and never hazards.
- Operand data: srcA/srcB data = WB_DATA if WB_VALID && WB_REG == src, else RDATA.
- Output mapping (ext per IMM_SIGNED, zero-ext for reg numbers and target):
  - R-type: D1 = reg1, D2 = A, D3 = B.
  - ADDI / LW: D1 = reg1, D2 = ext(im), D3 = 0.
  - SW: D1 = A, D2 = ext(im), D3 = 0.
  - BEQ: D1 = A, D2 = B, D3 = ext(offset).
  - JUMP: D1 = target, D2 = D3 = 0.
  - NOP / illegal: D1 = D2 = D3 = 0.
- Scoreboard: cnt[r] increments when OUTVALID && OUTREADY && WILLWRITE for STARTREG = r, and decrements when WB_VALID for WB_REG = r.
  - Simultaneous increment and decrement on the same register leaves cnt unchanged.
  - A decrement at 0 has no effect and is not an error.
- Hazard for a source s (s != 0): pending(s) = cnt[s] - (WB_VALID && WB_REG == s ? 1 : 0) > 0, OR (OUTVALID && WILLWRITE && STARTREG == s).
- Full condition: the destination's cnt is already at max -> stall.
- stall = INVALID && (any source hazard || full condition).
- INREADY = !stall && !FLUSH && (!OUTVALID || OUTREADY). Accepted when INVALID && INREADY.
- Latency: an accepted instruction appears at the outputs on the next posedge.
- Backpressure: while OUTVALID && !OUTREADY, all outputs hold stable.
- If the output register drains with no accept, OUTVALID falls to 0 and data outputs are zeroed.
- FLUSH (synchronous): next cycle OUTVALID = 0 and outputs are zeroed; the input is not accepted.
  - Scoreboard is unchanged by FLUSH, except that a handshake in the same cycle counts first.
- Reset: OUTVALID, WILLWRITE and ILLEGAL = 0; IROUT, PCOUT, DATAOUT1-3 and STARTREG = 0; all cnt = 0.
- RST takes priority over FLUSH and any handshake; reset mid-stream discards all state.

Test Plan:
- Reset, then ADD r3,r1,r2 with RDATA = 5, 7 -> next cycle OUTVALID = 1, D1 = 3, D2 = 5, D3 = 7, WILLWRITE = 1, STARTREG = 3.
- ADD r3,r1,r2 then SUB r4,r3,r1 back-to-back -> INREADY = 0 until WB_VALID with WB_REG = 3, WB_DATA = 0x0C; SUB issues that cycle with D2 = 0x0C (forwarded).
- ADDI r1, im = 0xF0 with IMM_SIGNED = 1 -> D2 = 0xFFF0; rerun with IMM_SIGNED = 0 -> D2 = 0x00F0.
- OUTREADY = 0 for 3 cycles with BEQ held -> outputs stable and INREADY = 0; OUTREADY = 1 -> handshake, next instruction accepted.
- Three LW r5 issued with no writeback (PEND_W = 2) -> cnt[5] = 3; a fourth LW r5 stalls until one WB to r5.
- FLUSH while OUTVALID = 1 and INVALID = 1 -> OUTVALID = 0 next cycle, input not taken; opcode 13 -> ILLEGAL = 1 and D1-3 = 0.
